// File: rtl/cla_pkg.sv
// Shared constants and the output bundle type for the 4-bit carry-lookahead unit.
package cla_pkg;

  localparam int CLA_WIDTH = 4;

  typedef struct packed {
    logic c1;
    logic c2;
    logic c3;
    logic c4;
    logic grp_g;
    logic grp_p;
  } cla_out_t;

  localparam cla_out_t CLA_OUT_RST = '0;

endpackage

// File: rtl/cla_logic.sv
// Combinational 4-bit lookahead; also usable as a second-level unit fed with group G/P.
module cla_logic
  import cla_pkg::*;
(
  input  logic [CLA_WIDTH-1:0] g,
  input  logic [CLA_WIDTH-1:0] p,
  input  logic                 cin,
  output cla_out_t             res
);

  // Every carry is a flat sum-of-products; none is built from another carry.
  always_comb begin
    res       = CLA_OUT_RST;
    res.c1    = g[0] | (p[0] & cin);
    res.c2    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    res.c3    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
    res.c4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
    res.grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    res.grp_p = p[3] & p[2] & p[1] & p[0];
  end

endmodule

// File: rtl/cla_adder.sv
// Registered 4-bit carry-lookahead unit: lookahead logic followed by one output register stage.
module cla_adder
  import cla_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic g0,
  input  logic g1,
  input  logic g2,
  input  logic g3,
  input  logic p0,
  input  logic p1,
  input  logic p2,
  input  logic p3,
  input  logic cin,
  output logic C1,
  output logic C2,
  output logic C3,
  output logic C4,
  output logic G,
  output logic P
);

  cla_out_t nxt;
  cla_out_t res_q;

  cla_logic u_logic (
    .g   ({g3, g2, g1, g0}),
    .p   ({p3, p2, p1, p0}),
    .cin (cin),
    .res (nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) res_q <= CLA_OUT_RST;
    else     res_q <= nxt;
  end

  assign C1 = res_q.c1;
  assign C2 = res_q.c2;
  assign C3 = res_q.c3;
  assign C4 = res_q.c4;
  assign G  = res_q.grp_g;
  assign P  = res_q.grp_p;

endmodule

// File: tb/tb_cla_adder.sv
// Bench for cla_adder: arithmetic carry model checked every cycle plus literal spot checks.
module tb_cla_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] g   = 4'h0;
  logic [3:0] p   = 4'h0;
  logic       cin = 1'b0;
  logic       c1_o, c2_o, c3_o, c4_o, gg_o, pp_o;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q = 6'h0;
  logic       exp_valid = 1'b0;

  always #5 clk = ~clk;

  cla_adder dut (
    .clk (clk), .rst (rst),
    .g0 (g[0]), .g1 (g[1]), .g2 (g[2]), .g3 (g[3]),
    .p0 (p[0]), .p1 (p[1]), .p2 (p[2]), .p3 (p[3]),
    .cin (cin),
    .C1 (c1_o), .C2 (c2_o), .C3 (c3_o), .C4 (c4_o),
    .G (gg_o), .P (pp_o)
  );

  // Model: map g/p onto operands a,b and let integer addition produce the carries.
  // a_i = g|p, b_i = g gives generate when g=1, propagate when only p=1, kill otherwise.
  // Result packing: {C1,C2,C3,C4,G,P}.
  function automatic logic [5:0] model(input logic [3:0] gv, input logic [3:0] pv,
                                       input logic ci);
    int a, b, s, s0;
    logic [5:0] r;
    a  = int'(gv | pv);
    b  = int'(gv);
    s  = a + b + int'(ci);
    s0 = a + b;
    r[5] = s[1] ^ a[1] ^ b[1];
    r[4] = s[2] ^ a[2] ^ b[2];
    r[3] = s[3] ^ a[3] ^ b[3];
    r[2] = s[4];
    r[1] = s0[4];
    r[0] = (pv == 4'hF);
    return r;
  endfunction

  function automatic logic [5:0] dut_out();
    return {c1_o, c2_o, c3_o, c4_o, gg_o, pp_o};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q     <= 6'h0;
      exp_valid <= 1'b1;
    end else if (exp_valid) begin
      exp_q <= model(g, p, cin);
    end
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (dut_out() !== exp_q) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%b expected=%b", $time, dut_out(), exp_q);
      end
    end
  end

  task automatic drive(input logic [3:0] gv, input logic [3:0] pv, input logic ci,
                       input logic r);
    g = gv; p = pv; cin = ci; rst = r;
  endtask

  // Waits for the edge that samples the current inputs, then checks #1 later.
  task automatic lit(input string name, input logic [5:0] expv);
    @(posedge clk); #1;
    checks++;
    if (dut_out() !== expv) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, dut_out(), expv);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    drive(4'hA, 4'h5, 1'b1, 1'b1);
    lit("reset_1", 6'b000000);
    drive(4'h7, 4'hF, 1'b1, 1'b1);
    lit("reset_2", 6'b000000);

    drive(4'b1101, 4'b1010, 1'b0, 1'b0);
    lit("mixed", 6'b111110);
    lit("mixed_hold", 6'b111110);

    drive(4'b0000, 4'b1111, 1'b1, 1'b0);
    lit("prop_cin1", 6'b111101);
    drive(4'b0000, 4'b1111, 1'b0, 1'b0);
    lit("prop_cin0", 6'b000001);

    drive(4'b0000, 4'b0000, 1'b1, 1'b0);
    lit("kill", 6'b000000);
    drive(4'b0001, 4'b1110, 1'b0, 1'b0);
    lit("gen_chain", 6'b111110);

    // Exhaustive sweep with a one-cycle reset in the middle.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      drive(v[3:0], v[7:4], v[8], (i == 200) ? 1'b1 : 1'b0);
      if (i == 200) lit("mid_reset", 6'b000000);
      else          begin @(posedge clk); #1; end
    end

    // Random stream with occasional resets.
    for (int i = 0; i < 300; i++) begin
      logic [8:0] v;
      v = 9'($urandom_range(0, 511));
      drive(v[3:0], v[7:4], v[8], ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
    end

    drive(4'h0, 4'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
